// File: rtl/fp_adder_arbiter_pkg.sv
// Shared definitions for the FP16 adder arbiter: field widths, FSM encoding,
// and a width helper used to size the grant index and the timeout counter.
package fp_adder_arbiter_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_W     = 1 + FP16_EXP_W + FP16_MAN_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_adder_arbiter_if.sv
// Bundles the requester-side and adder-side signals of the arbiter.
// slave = arbiter view; master = clients plus adder view.
interface fp_adder_arbiter_if
    import fp_adder_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = FP16_W
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;
    logic              fpa_add;
    logic [W-1:0]      fpa_num1;
    logic [W-1:0]      fpa_num2;
    logic [W-1:0]      fpa_result;
    logic              fpa_ready;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, fpa_result, fpa_ready,
        output req_ready, rsp_valid, rsp_result, rsp_err, fpa_add, fpa_num1, fpa_num2
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, fpa_result, fpa_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_err, fpa_add, fpa_num1, fpa_num2
    );

endinterface

// File: rtl/fp_adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request strictly after
// last_i (wrapping) wins, so the previous winner has lowest priority.
module rr_arbiter
    import fp_adder_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = cnt_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that skips an assignment would otherwise infer a latch.
        grant_o = '0;
        idx_o   = last_i;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last_i) + k) % NREQ);
            if (!any_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one FP16 adder between NREQ requesters: round-robin grant, add/ready
// sequencing with timeout, and result return to the owning requester.
module fp_adder_arbiter
    import fp_adder_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = FP16_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    fp_adder_arbiter_if.slave bus
);

    localparam int IDX_W = cnt_width(NREQ);
    localparam int TMO_W = cnt_width(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e           state_q;
    logic [IDX_W-1:0] last_grant_q;
    logic [NREQ-1:0]  req_ready_q;
    logic [NREQ-1:0]  rsp_valid_q;
    logic [W-1:0]     rsp_result_q;
    logic             rsp_err_q;
    logic             fpa_add_q;
    logic [W-1:0]     num1_q;
    logic [W-1:0]     num2_q;
    logic [TMO_W-1:0] tmo_q;

    logic [NREQ-1:0]  arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [W-1:0]     op_a_d;
    logic [W-1:0]     op_b_d;
    logic [NREQ-1:0]  owner_d;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i   (bus.req_valid),
        .last_i  (last_grant_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign op_a_d  = bus.req_a[arb_idx*W +: W];
    assign op_b_d  = bus.req_b[arb_idx*W +: W];
    // last_grant doubles as the owner of the transaction in flight.
    assign owner_d = NREQ'(1) << last_grant_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NREQ - 1);
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            fpa_add_q    <= 1'b0;
            num1_q       <= '0;
            num2_q       <= '0;
            tmo_q        <= '0;
        end else begin
            req_ready_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        req_ready_q  <= arb_grant;
                        last_grant_q <= arb_idx;
                        num1_q       <= op_a_d;
                        num2_q       <= op_b_d;
                        tmo_q        <= '0;
                        state_q      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // First BUSY cycle only raises fpa_add; ready is honoured
                    // solely while the adder is actually being driven.
                    if (!fpa_add_q) begin
                        fpa_add_q <= 1'b1;
                    end else if (bus.fpa_ready) begin
                        rsp_result_q <= bus.fpa_result;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= owner_d;
                        fpa_add_q    <= 1'b0;
                        state_q      <= ST_RESP;
                    end else if (tmo_q == TMO_LAST) begin
                        rsp_result_q <= '0;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= owner_d;
                        fpa_add_q    <= 1'b0;
                        state_q      <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if ((bus.rsp_ready & rsp_valid_q) != '0) begin
                        rsp_valid_q <= '0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.fpa_add    = fpa_add_q;
    assign bus.fpa_num1   = num1_q;
    assign bus.fpa_num2   = num2_q;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter: a small adder model, a response
// scoreboard popped by an independent monitor, and timing/boundary checks.
module tb_fp_adder_arbiter;

    import fp_adder_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TMO  = 16;
    localparam int LAT  = 3;
    localparam int BUDGET = 300;

    localparam logic [W-1:0] F17 = 16'h4C40;
    localparam logic [W-1:0] F18 = 16'h4C80;
    localparam logic [W-1:0] F34 = 16'h5040;
    localparam logic [W-1:0] F35 = 16'h5060;

    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mute = 1'b0;
    logic spur_rdy = 1'b0;
    logic model_rdy = 1'b0;
    int   lat_cnt = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    fp_adder_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    fp_adder_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.fpa_ready = model_rdy | spur_rdy;

    function automatic logic [W-1:0] add_lut(input logic [W-1:0] a, input logic [W-1:0] b);
        if ((a == F17 && b == F18) || (a == F18 && b == F17)) return F35;
        if (a == F17 && b == F17) return F34;
        return 16'hFFFF;
    endfunction

    // Adder model: result ready LAT cycles after fpa_add rises, until it drops.
    always @(negedge clk) begin
        if (bus.fpa_add && !mute) begin
            if (lat_cnt >= LAT - 1) begin
                model_rdy = 1'b1;
                bus.fpa_result = add_lut(bus.fpa_num1, bus.fpa_num2);
            end else begin
                lat_cnt = lat_cnt + 1;
            end
        end else begin
            lat_cnt = 0;
            model_rdy = 1'b0;
            bus.fpa_result = '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, BUDGET);
    endtask

    // Monitor: sample shortly after the negedge, once stimulus has settled.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.req_ready != '0)
            check("req_ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
        if (!rst && (bus.rsp_valid & bus.rsp_ready) != '0) begin
            check("rsp_valid_onehot", 32'($onehot(bus.rsp_valid)), 32'd1);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: actual rsp_valid=0x%0h required none", bus.rsp_valid);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_owner",  32'(bus.rsp_valid),  32'(1) << mon_e.idx);
                check("rsp_result", 32'(bus.rsp_result), 32'(mon_e.res));
                check("rsp_err",    32'(bus.rsp_err),    32'(mon_e.err));
            end
        end
    end

    task automatic wait_req_ready(input int idx);
        int n = 0;
        while (!bus.req_ready[idx] && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready[idx]) fail_timeout("wait_req_ready");
    endtask

    task automatic wait_fpa_add();
        int n = 0;
        while (!bus.fpa_add && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!bus.fpa_add) fail_timeout("wait_fpa_add");
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        while (bus.rsp_valid == '0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (bus.rsp_valid == '0) fail_timeout("wait_rsp_valid");
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || bus.rsp_valid != '0) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || bus.rsp_valid != '0) fail_timeout("wait_drain");
    endtask

    // Present one request, optionally record its expected response, and
    // return at the negedge where its req_ready is seen.
    task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic err, input bit push);
        bus.req_a[idx*W +: W] = a;
        bus.req_b[idx*W +: W] = b;
        bus.req_valid[idx] = 1'b1;
        if (push) sb_q.push_back('{idx, res, err});
        @(negedge clk);
        wait_req_ready(idx);
        bus.req_valid[idx] = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"},  32'(bus.req_ready),  32'd0);
        check({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
        check({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
        check({tag, "_rsp_err"},    32'(bus.rsp_err),    32'd0);
        check({tag, "_fpa_add"},    32'(bus.fpa_add),    32'd0);
        check({tag, "_fpa_num1"},   32'(bus.fpa_num1),   32'd0);
        check({tag, "_fpa_num2"},   32'(bus.fpa_num2),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pend[NREQ];
        int t0;
        int t1;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // 1: single request, 17 + 18 = 35
        issue(0, F17, F18, F35, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_req_ready_pulse", 32'(bus.req_ready), 32'd0);
        check("t1_fpa_add_rise",    32'(bus.fpa_add),   32'd1);
        check("t1_fpa_num1",        32'(bus.fpa_num1),  32'(F17));
        check("t1_fpa_num2",        32'(bus.fpa_num2),  32'(F18));
        wait_drain();

        // 2: all four requesting from reset priority; expected grants 0,1,2,3,0
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = F17;
            bus.req_b[i*W +: W] = F17;
            pend[i] = (i == 0) ? 2 : 1;
        end
        sb_q.push_back('{0, F34, 1'b0});
        sb_q.push_back('{1, F34, 1'b0});
        sb_q.push_back('{2, F34, 1'b0});
        sb_q.push_back('{3, F34, 1'b0});
        sb_q.push_back('{0, F34, 1'b0});
        bus.req_valid = '1;
        for (int n = 0; n < 4 * BUDGET && bus.req_valid != '0; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i] && pend[i] > 0) begin
                    pend[i]--;
                    if (pend[i] == 0) bus.req_valid[i] = 1'b0;
                end
            end
        end
        if (bus.req_valid != '0) fail_timeout("t2_grants");
        bus.req_valid = '0;
        wait_drain();

        // 3: adder never answers; error exactly TMO cycles after fpa_add rises
        mute = 1'b1;
        issue(1, F17, F18, '0, 1'b1, 1'b1);
        wait_fpa_add();
        t0 = cyc;
        wait_rsp_valid();
        t1 = cyc;
        check("t3_timeout_cycles", 32'(t1 - t0), 32'(TMO));
        check("t3_fpa_add_low",    32'(bus.fpa_add), 32'd0);
        wait_drain();
        mute = 1'b0;

        // 4: owner withholds rsp_ready; response held, no new grant
        bus.rsp_ready = 4'b1011;
        issue(2, F17, F18, F35, 1'b0, 1'b1);
        wait_rsp_valid();
        bus.req_a[0 +: W] = F17;
        bus.req_b[0 +: W] = F17;
        bus.req_valid[0] = 1'b1;
        sb_q.push_back('{0, F34, 1'b0});
        repeat (10) begin
            @(negedge clk);
            check("t4_rsp_valid_hold",  32'(bus.rsp_valid),  32'h4);
            check("t4_rsp_result_hold", 32'(bus.rsp_result), 32'(F35));
            check("t4_no_req_ready",    32'(bus.req_ready),  32'd0);
            check("t4_fpa_add_low",     32'(bus.fpa_add),    32'd0);
        end
        bus.rsp_ready[2] = 1'b1;
        wait_req_ready(0);
        bus.req_valid[0] = 1'b0;
        wait_drain();

        // 5: reset in BUSY aborts silently; req3 then completes normally
        bus.rsp_ready = '1;
        issue(3, F17, F18, '0, 1'b0, 1'b0);
        wait_fpa_add();
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("t5_abort");
        rst = 1'b0;
        issue(3, F17, F18, F35, 1'b0, 1'b1);
        wait_drain();

        // 6: spurious fpa_ready in IDLE, foreign rsp_ready during RESP
        repeat (2) @(negedge clk);
        spur_rdy = 1'b1;
        @(negedge clk);
        spur_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("t6_idle_fpa_add",   32'(bus.fpa_add),   32'd0);
            check("t6_idle_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 4'b0001;
        issue(1, F17, F17, F34, 1'b0, 1'b1);
        wait_rsp_valid();
        repeat (5) begin
            @(negedge clk);
            check("t6_rsp_valid_hold",  32'(bus.rsp_valid),  32'h2);
            check("t6_rsp_result_hold", 32'(bus.rsp_result), 32'(F34));
            check("t6_fpa_add_low",     32'(bus.fpa_add),    32'd0);
        end
        bus.rsp_ready = 4'b0011;
        wait_drain();
        @(negedge clk);
        check("t6_rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
